// File: rtl/formatter.sv
// Store-and-forward formatter: buffers one arbiter packet in a local FIFO,
// requests the receiver, then streams the packet with start/end framing.
module formatter #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              f2a_id_req_o,
  output logic              f2a_ack_o,
  input  logic              a2f_val_i,
  input  logic [1:0]        a2f_id_i,
  input  logic [DATA_W-1:0] a2f_data_i,
  input  logic [2:0]        a2f_pkglen_sel_i,
  output logic              fmt_req_o,
  input  logic              fmt_grant_i,
  output logic [1:0]        fmt_chid_o,
  output logic [5:0]        fmt_length_o,
  output logic [DATA_W-1:0] fmt_data_o,
  output logic              fmt_start_o,
  output logic              fmt_end_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ID_REQ = 3'd1;
  localparam logic [2:0] S_RECV   = 3'd2;
  localparam logic [2:0] S_REQ    = 3'd3;
  localparam logic [2:0] S_SEND   = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic [5:0]        r_wr_cnt;
  logic [5:0]        r_rd_cnt;
  logic [5:0]        r_length;
  logic [1:0]        r_chid;
  logic [5:0]        w_len_dec;
  logic              w_wr;
  logic              w_rd;
  logic              w_last_wr;
  logic              w_last_rd;

  // Codes above 3 saturate at the largest packet.
  always_comb begin
    case (a2f_pkglen_sel_i)
      3'd0:    w_len_dec = 6'd4;
      3'd1:    w_len_dec = 6'd8;
      3'd2:    w_len_dec = 6'd16;
      default: w_len_dec = 6'd32;
    endcase
  end

  assign w_wr      = a2f_val_i && ((r_state == S_ID_REQ) || (r_state == S_RECV));
  assign w_rd      = (r_state == S_SEND);
  assign w_last_wr = (r_state == S_ID_REQ) ? (w_len_dec == 6'd1)
                                           : ((r_wr_cnt + 6'd1) == r_length);
  assign w_last_rd = (r_rd_cnt == (r_length - 6'd1));

  // NOTE: the next state gets a default before the case so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   w_next_state = S_ID_REQ;
      S_ID_REQ: if (w_wr) w_next_state = w_last_wr ? S_REQ : S_RECV;
      S_RECV:   if (w_wr && w_last_wr) w_next_state = S_REQ;
      S_REQ:    if (fmt_grant_i) w_next_state = S_SEND;
      S_SEND:   if (w_last_rd) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_length <= '0;
      r_chid   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_wr) begin
        r_wr_ptr <= (r_wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
        r_count  <= r_count + (AW+1)'(1);
        if (r_state == S_ID_REQ) begin
          r_chid   <= a2f_id_i;
          r_length <= w_len_dec;
          r_wr_cnt <= 6'd1;
        end else begin
          r_wr_cnt <= r_wr_cnt + 6'd1;
        end
      end
      if (w_rd) begin
        r_rd_ptr <= (r_rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
        r_count  <= r_count - (AW+1)'(1);
        r_rd_cnt <= w_last_rd ? 6'd0 : r_rd_cnt + 6'd1;
      end
    end
  end

  // NOTE: the buffer array has no reset; pointers and count define its contents.
  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wr_ptr] <= a2f_data_i;
  end

  assign f2a_id_req_o = (r_state == S_ID_REQ);
  assign f2a_ack_o    = w_wr;
  assign fmt_req_o    = (r_state == S_REQ);
  assign fmt_chid_o   = r_chid;
  assign fmt_length_o = r_length;
  assign fmt_data_o   = w_rd ? r_mem[r_rd_ptr] : '0;
  assign fmt_start_o  = w_rd && (r_rd_cnt == 6'd0);
  assign fmt_end_o    = w_rd && w_last_rd;

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_wr && (r_count == (AW+1)'(FIFO_DEPTH))))
    else $error("formatter: FIFO overflow");
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_rd && (r_count == '0)))
    else $error("formatter: FIFO underflow");
`endif

endmodule

// File: tb/tb_formatter.sv
// Directed bench for formatter: reset, packet lengths, val gaps, grant timing
// and a mid-SEND reset, against hand-computed expected values.
module tb_formatter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        f2a_id_req_o;
  logic        f2a_ack_o;
  logic        a2f_val_i;
  logic [1:0]  a2f_id_i;
  logic [31:0] a2f_data_i;
  logic [2:0]  a2f_pkglen_sel_i;
  logic        fmt_req_o;
  logic        fmt_grant_i;
  logic [1:0]  fmt_chid_o;
  logic [5:0]  fmt_length_o;
  logic [31:0] fmt_data_o;
  logic        fmt_start_o;
  logic        fmt_end_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  formatter #(.DATA_W(32), .FIFO_DEPTH(32)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .f2a_id_req_o     (f2a_id_req_o),
    .f2a_ack_o        (f2a_ack_o),
    .a2f_val_i        (a2f_val_i),
    .a2f_id_i         (a2f_id_i),
    .a2f_data_i       (a2f_data_i),
    .a2f_pkglen_sel_i (a2f_pkglen_sel_i),
    .fmt_req_o        (fmt_req_o),
    .fmt_grant_i      (fmt_grant_i),
    .fmt_chid_o       (fmt_chid_o),
    .fmt_length_o     (fmt_length_o),
    .fmt_data_o       (fmt_data_o),
    .fmt_start_o      (fmt_start_o),
    .fmt_end_o        (fmt_end_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {f2a_id_req_o, f2a_ack_o, fmt_req_o, fmt_start_o, fmt_end_o,
            fmt_chid_o, fmt_length_o} | fmt_data_o;
  endfunction

  // Entered in ID_REQ; accepts len words base+0.. and ends with the DUT in REQ.
  task automatic feed(input logic [1:0] id, input logic [2:0] sel, input logic [31:0] base,
                      input int len, input bit toggle);
    int k = 0;
    int c = 0;
    while (k < len) begin
      a2f_val_i        = toggle ? ((c % 2) == 0) : 1'b1;
      a2f_data_i       = a2f_val_i ? base + 32'(k) : 32'hFFFF_FFFF;
      a2f_id_i         = (k == 0) ? id : ~id;
      a2f_pkglen_sel_i = (k == 0) ? sel : 3'd0;
      @(negedge clk_i);
      check("feed_ack", {31'd0, f2a_ack_o}, {31'd0, a2f_val_i});
      check("feed_id_req", {31'd0, f2a_id_req_o}, {31'd0, k == 0});
      next_cycle();
      if (a2f_val_i) k++;
      c++;
    end
    a2f_val_i = 1'b0;
  endtask

  // Entered in REQ; grants after 'delay' cycles and checks the streamed packet.
  task automatic drain(input logic [1:0] id, input int len, input logic [31:0] base,
                       input int delay, input logic keep_grant, input int abort_at);
    int n_start = 0;
    int n_end   = 0;
    for (int d = 0; d <= delay; d++) begin
      fmt_grant_i = (d == delay) ? 1'b1 : 1'b0;
      @(negedge clk_i);
      check("req_high", {31'd0, fmt_req_o}, 32'd1);
      check("req_chid", {30'd0, fmt_chid_o}, {30'd0, id});
      check("req_len", {26'd0, fmt_length_o}, 32'(len));
      check("req_no_ack", {31'd0, f2a_ack_o | f2a_id_req_o}, 32'd0);
      next_cycle();
    end
    fmt_grant_i = keep_grant;
    for (int i = 0; i < len; i++) begin
      if (i == abort_at) begin
        rst_i = 1'b1;
        @(negedge clk_i);
        check("abort_no_end", {31'd0, fmt_end_o}, 32'd0);
        next_cycle();
        rst_i = 1'b0;
        a2f_val_i = 1'b0;
        @(negedge clk_i);
        check("abort_outs_zero", all_outs(), 32'd0);
        next_cycle();
        return;
      end
      @(negedge clk_i);
      check("send_data", fmt_data_o, base + 32'(i));
      check("send_start", {31'd0, fmt_start_o}, {31'd0, i == 0});
      check("send_end", {31'd0, fmt_end_o}, {31'd0, i == len - 1});
      check("send_req_low", {31'd0, fmt_req_o | f2a_ack_o}, 32'd0);
      check("send_len", {26'd0, fmt_length_o}, 32'(len));
      if (fmt_start_o) n_start++;
      if (fmt_end_o) n_end++;
      next_cycle();
    end
    check("start_count", 32'(n_start), 32'd1);
    check("end_count", 32'(n_end), 32'd1);
    a2f_val_i = 1'b0;
    @(negedge clk_i);
    check("post_idle", {f2a_id_req_o, f2a_ack_o, fmt_req_o, fmt_start_o, fmt_end_o}, 32'd0);
    check("post_data", fmt_data_o, 32'd0);
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1;
    a2f_val_i = 1'b1;
    a2f_id_i = 2'd0;
    a2f_data_i = 32'h1234_5678;
    a2f_pkglen_sel_i = 3'd0;
    fmt_grant_i = 1'b0;

    // T1: reset with val high, then one IDLE cycle
    next_cycle();
    next_cycle();
    @(negedge clk_i);
    check("reset_outs_zero", all_outs(), 32'd0);
    next_cycle();
    rst_i = 1'b0;
    a2f_val_i = 1'b0;
    @(negedge clk_i);
    check("release_idle", {31'd0, f2a_id_req_o}, 32'd0);
    next_cycle();

    // T2: id=2, len 8, grant after 3 cycles
    feed(2'd2, 3'd1, 32'hA0, 8, 1'b0);
    drain(2'd2, 8, 32'hA0, 3, 1'b0, -1);

    // T3: len 4 with toggling val; a fifth valid word is ignored
    feed(2'd0, 3'd0, 32'hB0, 4, 1'b1);
    a2f_val_i = 1'b1;
    a2f_data_i = 32'h5555_5555;
    drain(2'd0, 4, 32'hB0, 2, 1'b0, -1);

    // T4: len 32 with grant tied high
    fmt_grant_i = 1'b1;
    feed(2'd3, 3'd3, 32'h100, 32, 1'b0);
    drain(2'd3, 32, 32'h100, 0, 1'b1, -1);

    // T5: saturated length code
    feed(2'd1, 3'd6, 32'h200, 32, 1'b0);
    drain(2'd1, 32, 32'h200, 1, 1'b0, -1);

    // T6: reset during SEND, then a clean packet
    feed(2'd3, 3'd2, 32'h300, 16, 1'b0);
    drain(2'd3, 16, 32'h300, 0, 1'b0, 5);
    feed(2'd1, 3'd0, 32'hC0, 4, 1'b0);
    drain(2'd1, 4, 32'hC0, 1, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
